fixed_point_divider: RTL and testbench



---
 rtl/fixed_point_divider.sv | 167 ++++++++++++++++
 tb/tb_fixed_point_divider.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// rtl/fixed_point_divider.sv - sequential signed Q-format divider, restoring, one quotient bit per clock
module fixed_point_divider #(
  parameter int Q = 20,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] POS_LIMIT = {{(Q+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [W-1:0] NEG_LIMIT = {{Q{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] POS_SAT   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_SAT   = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic           zero_div_q, zero_div_d;
  logic [N-1:0]   mag_b_q, mag_b_d;
  logic [W-1:0]   dividend_q, dividend_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b_in;
  logic [N:0]     rem_shift;
  logic           rem_ge;
  logic [N-1:0]   rem_sub;

  // |-2^(N-1)| wraps to 2^(N-1), which is exact when read as unsigned
  assign mag_a     = a[N-1] ? (~a + 1'b1) : a;
  assign mag_b_in  = b[N-1] ? (~b + 1'b1) : b;
  assign rem_shift = {rem_q, dividend_q[W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, mag_b_q});
  // The true difference is below mag_b, so N bits hold it exactly
  assign rem_sub   = rem_shift[N-1:0] - mag_b_q;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    zero_div_d = zero_div_q;
    mag_b_d    = mag_b_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (b == '0) begin
            zero_div_d = 1'b1;
            sign_d     = a[N-1];
            state_d    = DONE;
          end else begin
            zero_div_d = 1'b0;
            sign_d     = a[N-1] ^ b[N-1];
            mag_b_d    = mag_b_in;
            dividend_d = {mag_a, {Q{1'b0}}};
            rem_d      = '0;
            quot_d     = '0;
            cnt_d      = '0;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        dividend_d = dividend_q << 1;
        rem_d      = rem_ge ? rem_sub : rem_shift[N-1:0];
        quot_d     = {quot_q[W-2:0], rem_ge};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (zero_div_q) begin
          result_d = sign_q ? NEG_SAT : POS_SAT;
          dbz_d    = 1'b1;
          ovf_d    = 1'b0;
        end else if (!sign_q) begin
          if (quot_q > POS_LIMIT) begin
            result_d = POS_SAT;
            ovf_d    = 1'b1;
          end else begin
            result_d = quot_q[N-1:0];
          end
        end else begin
          if (quot_q > NEG_LIMIT) begin
            result_d = NEG_SAT;
            ovf_d    = 1'b1;
          end else begin
            result_d = ~quot_q[N-1:0] + 1'b1;
          end
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      zero_div_q <= 1'b0;
      mag_b_q    <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      zero_div_q <= zero_div_d;
      mag_b_q    <= mag_b_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// tb/tb_fixed_point_divider.sv - directed vector bench for fixed_point_divider
module tb_fixed_point_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_result;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  fixed_point_divider #(.Q(20), .N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .out_valid   (out_valid),
    .result      (result),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits for out_valid after an accept; returns edges counted (0 if never seen)
  task automatic wait_valid(output int lat);
    bit seen;
    int n;
    seen = 0;
    n = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) seen = 1;
    end
    lat = seen ? n : 0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({v.name, " busy@accept"}, {31'd0, busy}, 32'd1);
    chk({v.name, " flags cleared"}, {30'd0, overflow, div_by_zero}, 32'd0);
    chk({v.name, " result held"}, result, prev_result);
    wait_valid(lat);
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " result"}, result, v.res);
    chk({v.name, " overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
    chk({v.name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
    chk({v.name, " busy@valid"}, {31'd0, busy}, 32'd0);
    prev_result = v.res;
  endtask

  initial begin
    int lat;
    int pulses;

    vecs[0]  = '{"3.0/1.5",      32'h0030_0000, 32'h0018_0000, 32'h0020_0000, 1'b0, 1'b0, 53};
    vecs[1]  = '{"-1/4",         32'hFFF0_0000, 32'h0040_0000, 32'hFFFC_0000, 1'b0, 1'b0, 53};
    vecs[2]  = '{"-1/-4",        32'hFFF0_0000, 32'hFFC0_0000, 32'h0004_0000, 1'b0, 1'b0, 53};
    vecs[3]  = '{"1/0",          32'h0010_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
    vecs[4]  = '{"-1/0",         32'hFFF0_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1};
    vecs[5]  = '{"big/lsb",      32'h7FF0_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 53};
    vecs[6]  = '{"-2048/1",      32'h8000_0000, 32'h0010_0000, 32'h8000_0000, 1'b0, 1'b0, 53};
    vecs[7]  = '{"0/3",          32'h0000_0000, 32'h0030_0000, 32'h0000_0000, 1'b0, 1'b0, 53};
    vecs[8]  = '{"1/3",          32'h0010_0000, 32'h0030_0000, 32'h0005_5555, 1'b0, 1'b0, 53};
    vecs[9]  = '{"-1/3",         32'hFFF0_0000, 32'h0030_0000, 32'hFFFA_AAAB, 1'b0, 1'b0, 53};
    vecs[10] = '{"-2048/-1",     32'h8000_0000, 32'hFFF0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 53};
    vecs[11] = '{"2.5/2",        32'h0028_0000, 32'h0020_0000, 32'h0014_0000, 1'b0, 1'b0, 53};
    vecs[12] = '{"-2048/0.99",   32'h8000_0000, 32'h000F_FFFF, 32'h8000_0000, 1'b1, 1'b0, 53};
    vecs[13] = '{"0/0",          32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    prev_result = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {busy, out_valid, overflow, div_by_zero, result[27:0]}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
    end

    // Second start mid-division must be ignored
    @(posedge clk); #1;
    a = 32'h0030_0000;
    b = 32'h0018_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    a = 32'h0010_0000;
    b = 32'h0000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(lat);
    chk("ignored start latency", lat, 32'd43);
    chk("ignored start result", result, 32'h0020_0000);
    chk("ignored start dbz", {31'd0, div_by_zero}, 32'd0);

    // Start on the out_valid cycle is accepted
    a = 32'h0060_0000;
    b = 32'h0020_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy", {31'd0, busy}, 32'd1);
    chk("b2b out_valid low", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-division
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {28'd0, busy, out_valid, overflow, div_by_zero}, 32'd0);
    chk("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) pulses++;
    end
    chk("no output after reset", pulses, 32'd0);

    prev_result = '0;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
